// File: rtl/adc_capture.sv
// adc_capture: multi-channel capture buffer.
//
// Captures {time_curr, sig} records into an on-chip FIFO and streams them out
// over a valid/ready interface. Capture starts on arm, either immediately or
// on a signed rising-threshold crossing of one channel. Records are taken
// every decim+1 cycles until n_samp records have been strobed.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   time_curr     current emulated time, stored with each record
//   sig           n_ch signed samples, channel k at [k*sig_bits +: sig_bits]
//   arm           single-cycle start request (ignored while busy)
//   trig_en       1 = wait for trigger, 0 = capture right after arm
//   trig_ch       trigger source channel            (latched on arm)
//   trig_thresh   signed trigger threshold          (latched on arm)
//   decim         record every decim+1 cycles       (latched on arm)
//   n_samp        records per shot, 0/>depth = depth (latched on arm)
//   out_valid/out_ready/out_time/out_sig   show-ahead record stream
//   busy          ARMED or CAPTURE
//   done          DONE
//   drop_cnt      saturating count of records lost to a full buffer
module adc_capture #(
  parameter int n_ch       = 4,
  parameter int sig_bits   = 8,
  parameter int time_bits  = 32,
  parameter int depth      = 16,
  parameter int decim_bits = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [time_bits-1:0]       time_curr,
  input  logic [n_ch*sig_bits-1:0]   sig,
  input  logic                       arm,
  input  logic                       trig_en,
  input  logic [((n_ch > 1) ? $clog2(n_ch) : 1)-1:0] trig_ch,
  input  logic [sig_bits-1:0]        trig_thresh,
  input  logic [decim_bits-1:0]      decim,
  input  logic [$clog2(depth):0]     n_samp,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [time_bits-1:0]       out_time,
  output logic [n_ch*sig_bits-1:0]   out_sig,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 drop_cnt
);

  localparam int CW = (n_ch > 1) ? $clog2(n_ch) : 1;
  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;
  localparam int SW = n_ch * sig_bits;
  localparam int DW = time_bits + SW;
  localparam logic [PW-1:0] DEPTH_P = PW'(depth);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Select one signed channel; out-of-range indices read as zero.
  function automatic logic signed [sig_bits-1:0] get_ch(
    input logic [SW-1:0] s,
    input logic [CW-1:0] idx
  );
    logic signed [sig_bits-1:0] r;
    r = '0;
    for (int k = 0; k < n_ch; k++) begin
      if (idx == CW'(k)) begin
        r = s[k*sig_bits +: sig_bits];
      end
    end
    return r;
  endfunction

  state_t                      state_q, state_d;
  logic [CW-1:0]               trig_ch_q, trig_ch_d;
  logic signed [sig_bits-1:0]  thresh_q, thresh_d;
  logic [decim_bits-1:0]       decim_q, decim_d;
  logic [PW-1:0]               n_eff_q, n_eff_d;
  logic [decim_bits-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]               rec_q, rec_d;
  logic signed [sig_bits-1:0]  prev_q, prev_d;
  logic [PW-1:0]               wr_q, wr_d, rd_q, rd_d;
  logic                        out_valid_q, out_valid_d;
  logic [time_bits-1:0]        out_time_q, out_time_d;
  logic [SW-1:0]               out_sig_q, out_sig_d;
  logic [7:0]                  drop_cnt_q, drop_cnt_d;
  logic [DW-1:0]               mem_q [depth];

  logic                        arm_ok_s;
  logic                        strobe_s;
  logic signed [sig_bits-1:0]  cur_s;
  logic [PW-1:0]               rec_inc_s;
  logic                        pop_s, full_s, wr_en_s, drop_s;
  logic [DW-1:0]               rd_data_s;

  // Capture control: state machine, latched configuration, strobe generation.
  always_comb begin
    state_d   = state_q;
    trig_ch_d = trig_ch_q;
    thresh_d  = thresh_q;
    decim_d   = decim_q;
    n_eff_d   = n_eff_q;
    cnt_d     = cnt_q;
    rec_d     = rec_q;
    strobe_s  = 1'b0;
    arm_ok_s  = 1'b0;
    cur_s     = get_ch(sig, trig_ch_q);
    rec_inc_s = rec_q + PW'(1);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          arm_ok_s  = 1'b1;
          trig_ch_d = trig_ch;
          thresh_d  = trig_thresh;
          decim_d   = decim;
          n_eff_d   = ((n_samp == '0) || (n_samp > DEPTH_P)) ? DEPTH_P : n_samp;
          cnt_d     = '0;
          rec_d     = '0;
          state_d   = trig_en ? S_ARMED : S_CAPTURE;
        end else begin
          state_d = state_q;
        end
      end
      S_ARMED: begin
        // The trigger cycle itself is record 0, so the decimation counter
        // continues from 1 rather than restarting at 0.
        if ((prev_q < thresh_q) && (cur_s >= thresh_q)) begin
          strobe_s = 1'b1;
          rec_d    = PW'(1);
          cnt_d    = (decim_q == '0) ? '0 : decim_bits'(1);
          state_d  = (n_eff_q == PW'(1)) ? S_DONE : S_CAPTURE;
        end else begin
          state_d = S_ARMED;
        end
      end
      S_CAPTURE: begin
        cnt_d = (cnt_q == decim_q) ? '0 : cnt_q + decim_bits'(1);
        if (cnt_q == '0) begin
          strobe_s = 1'b1;
          rec_d    = rec_inc_s;
          state_d  = (rec_inc_s == n_eff_q) ? S_DONE : S_CAPTURE;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // On the arm cycle track the newly selected channel so the first ARMED
    // cycle compares against the right history.
    prev_d = get_ch(sig, arm_ok_s ? trig_ch : trig_ch_q);
  end

  // Buffer control: write acceptance, drops, pointers, show-ahead output.
  always_comb begin
    pop_s   = out_valid_q & out_ready;
    full_s  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    wr_en_s = strobe_s & (~full_s | pop_s);
    drop_s  = strobe_s & ~wr_en_s;
    wr_d    = wr_q + PW'(wr_en_s);
    rd_d    = rd_q + PW'(pop_s);

    if (drop_s && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end

    // Uses the pre-write pointer so a fresh record shows one cycle after it
    // lands in memory; the memory read likewise sees pre-write contents.
    rd_data_s   = mem_q[rd_d[AW-1:0]];
    out_valid_d = (wr_q != rd_d);
    if (out_valid_d) begin
      out_time_d = rd_data_s[DW-1 -: time_bits];
      out_sig_d  = rd_data_s[SW-1:0];
    end else begin
      out_time_d = out_time_q;
      out_sig_d  = out_sig_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      trig_ch_q   <= '0;
      thresh_q    <= '0;
      decim_q     <= '0;
      n_eff_q     <= DEPTH_P;
      cnt_q       <= '0;
      rec_q       <= '0;
      prev_q      <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      out_time_q  <= '0;
      out_sig_q   <= '0;
      drop_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      trig_ch_q   <= trig_ch_d;
      thresh_q    <= thresh_d;
      decim_q     <= decim_d;
      n_eff_q     <= n_eff_d;
      cnt_q       <= cnt_d;
      rec_q       <= rec_d;
      prev_q      <= prev_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      out_time_q  <= out_time_d;
      out_sig_q   <= out_sig_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Record storage; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_q[AW-1:0]] <= {time_curr, sig};
    end
  end

  assign out_valid = out_valid_q;
  assign out_time  = out_time_q;
  assign out_sig   = out_sig_q;
  assign drop_cnt  = drop_cnt_q;
  assign busy      = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture with n_ch=4, sig_bits=8, depth=16.
module tb_adc_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] time_curr;
  logic [31:0] sig;
  logic        arm;
  logic        trig_en;
  logic [1:0]  trig_ch;
  logic [7:0]  trig_thresh;
  logic [7:0]  decim;
  logic [4:0]  n_samp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_time;
  logic [31:0] out_sig;
  logic        busy;
  logic        done;
  logic [7:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;
  logic [63:0] rec_q[$];

  adc_capture #(
    .n_ch(4), .sig_bits(8), .time_bits(32), .depth(16), .decim_bits(8)
  ) dut (
    .clk(clk), .rst(rst), .time_curr(time_curr), .sig(sig), .arm(arm),
    .trig_en(trig_en), .trig_ch(trig_ch), .trig_thresh(trig_thresh),
    .decim(decim), .n_samp(n_samp), .out_valid(out_valid),
    .out_ready(out_ready), .out_time(out_time), .out_sig(out_sig),
    .busy(busy), .done(done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Record every handshake that will happen at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) rec_q.push_back({out_time, out_sig});
  end

  task automatic tick();
    @(posedge clk);
    #1;
    time_curr = time_curr + 32'd1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] c3, input logic [7:0] c2,
                                     input logic [7:0] c1, input logic [7:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  // Arm with the given settings; t_arm is the time stamp of the arm edge.
  task automatic arm_shot(input logic te, input logic [7:0] dc, input logic [4:0] ns,
                          output logic [31:0] t_arm);
    trig_en = te;
    decim   = dc;
    n_samp  = ns;
    arm     = 1'b1;
    t_arm   = time_curr;
    tick();
    arm     = 1'b0;
  endtask

  initial begin
    logic [31:0] ta, tb2, tt, t1, t2, tf;
    rst = 1'b1; time_curr = 32'd0; sig = 32'd0; arm = 1'b0; trig_en = 1'b0;
    trig_ch = 2'd0; trig_thresh = 8'd0; decim = 8'd0; n_samp = 5'd0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_drop", drop_cnt, 8'd0);
    check("rst_time", out_time, 32'd0);
    check("rst_sig", out_sig, 32'd0);
    rst = 1'b0;
    tick();

    // Immediate capture, 4 records, every cycle.
    sig = mk(8'd1, 8'd2, 8'd3, 8'd4);
    rec_q.delete();
    arm_shot(1'b0, 8'd0, 5'd4, ta);
    check("t1_busy", busy, 1'b1);
    check("t1_done0", done, 1'b0);
    tick();
    check("t1_lat_valid0", out_valid, 1'b0);
    tick();
    check("t1_lat_valid1", out_valid, 1'b1);
    check("t1_lat_time", out_time, ta + 32'd1);
    tick();
    check("t1_done_early", done, 1'b0);
    tick();
    check("t1_done", done, 1'b1);
    check("t1_busy_end", busy, 1'b0);
    repeat (4) tick();
    check("t1_count", 64'(rec_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("t1_time", rec_q[i][63:32], ta + 32'd1 + 32'(i));
    check("t1_sig", rec_q[0][31:0], mk(8'd1, 8'd2, 8'd3, 8'd4));

    // Rising-threshold trigger on channel 2; a step on channel 1 is ignored.
    trig_ch = 2'd2; trig_thresh = 8'd0;
    sig = mk(8'd0, 8'hFD, 8'hFD, 8'd0);
    rec_q.delete();
    arm_shot(1'b1, 8'd0, 5'd2, ta);
    check("t2_armed", busy, 1'b1);
    sig = mk(8'd0, 8'hFD, 8'h03, 8'd0);
    tick(); tick();
    check("t2_ch1_busy", busy, 1'b1);
    check("t2_ch1_done", done, 1'b0);
    check("t2_ch1_none", 64'(rec_q.size()), 64'd0);
    sig = mk(8'd0, 8'hFE, 8'h03, 8'd0); tick();
    sig = mk(8'd0, 8'hFF, 8'h03, 8'd0); tick();
    check("t2_pre_trig", busy, 1'b1);
    sig = mk(8'd0, 8'h00, 8'h03, 8'd0);
    tt = time_curr;
    tick();
    sig = mk(8'd0, 8'h01, 8'h03, 8'd0);
    tick();
    check("t2_done", done, 1'b1);
    repeat (4) tick();
    check("t2_count", 64'(rec_q.size()), 64'd2);
    check("t2_rec0", rec_q[0], {tt, mk(8'd0, 8'h00, 8'h03, 8'd0)});
    check("t2_rec1", rec_q[1], {tt + 32'd1, mk(8'd0, 8'h01, 8'h03, 8'd0)});

    // Decimation by 3.
    sig = mk(8'd5, 8'd6, 8'd7, 8'd8);
    rec_q.delete();
    arm_shot(1'b0, 8'd2, 5'd3, ta);
    repeat (12) tick();
    check("t3_done", done, 1'b1);
    check("t3_count", 64'(rec_q.size()), 64'd3);
    check("t3_time0", rec_q[0][63:32], ta + 32'd1);
    check("t3_time1", rec_q[1][63:32], ta + 32'd4);
    check("t3_time2", rec_q[2][63:32], ta + 32'd7);

    // Overflow: 8 + 13 records into a 16-deep buffer -> 5 drops.
    out_ready = 1'b0;
    rec_q.delete();
    arm_shot(1'b0, 8'd0, 5'd8, t1);
    repeat (10) tick();
    check("t4_done1", done, 1'b1);
    check("t4_drop1", drop_cnt, 8'd0);
    arm_shot(1'b0, 8'd0, 5'd13, t2);
    repeat (16) tick();
    check("t4_done2", done, 1'b1);
    check("t4_drop2", drop_cnt, 8'd5);
    check("t4_hold_valid", out_valid, 1'b1);
    check("t4_hold_time", out_time, t1 + 32'd1);
    out_ready = 1'b1;
    repeat (20) tick();
    check("t4_count", 64'(rec_q.size()), 64'd16);
    for (int i = 0; i < 8; i++) begin
      check("t4_old", rec_q[i][63:32], t1 + 32'd1 + 32'(i));
      check("t4_new", rec_q[8 + i][63:32], t2 + 32'd1 + 32'(i));
    end

    // Full buffer, consumer accepts exactly on strobe cycles -> no drops.
    out_ready = 1'b0;
    rec_q.delete();
    arm_shot(1'b0, 8'd0, 5'd16, tf);
    repeat (18) tick();
    check("t5_full_valid", out_valid, 1'b1);
    arm_shot(1'b0, 8'd2, 5'd4, ta);
    for (int i = 0; i < 12; i++) begin
      out_ready = (time_curr == ta + 32'd1) || (time_curr == ta + 32'd4) ||
                  (time_curr == ta + 32'd7) || (time_curr == ta + 32'd10);
      tick();
    end
    out_ready = 1'b0;
    check("t5_drop", drop_cnt, 8'd5);
    check("t5_done", done, 1'b1);
    check("t5_pops", 64'(rec_q.size()), 64'd4);
    out_ready = 1'b1;
    repeat (22) tick();
    check("t5_count", 64'(rec_q.size()), 64'd20);
    check("t5_first", rec_q[0][63:32], tf + 32'd1);
    check("t5_last_old", rec_q[15][63:32], tf + 32'd16);
    check("t5_new0", rec_q[16][63:32], ta + 32'd1);
    check("t5_new3", rec_q[19][63:32], ta + 32'd10);

    // Reset during capture with records buffered.
    out_ready = 1'b0;
    rec_q.delete();
    arm_shot(1'b0, 8'd0, 5'd8, ta);
    repeat (3) tick();
    check("t6_pre_valid", out_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("t6_valid", out_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_done", done, 1'b0);
    check("t6_drop", drop_cnt, 8'd0);
    check("t6_time", out_time, 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    arm_shot(1'b0, 8'd0, 5'd2, tb2);
    repeat (6) tick();
    check("t6_rearm_done", done, 1'b1);
    check("t6_rearm_count", 64'(rec_q.size()), 64'd2);
    check("t6_rearm_t0", rec_q[0][63:32], tb2 + 32'd1);
    check("t6_rearm_t1", rec_q[1][63:32], tb2 + 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
